// File: rtl/inst_axi_bridge.sv
// Instruction-fetch to AXI4 read bridge: one 16-byte group per request, fetched
// as a 4-beat INCR burst of 32-bit words, with a single fetch in flight.
module inst_axi_bridge #(
    parameter logic [3:0] AXI_ID = 4'd0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inst_req,
    input  logic [31:0]  inst_addr,
    output logic         inst_addr_ok,
    output logic         inst_data_ok,
    output logic [127:0] inst_rdata,
    output logic         inst_bus_err,
    output logic [3:0]   arid,
    output logic [31:0]  araddr,
    output logic [7:0]   arlen,
    output logic [2:0]   arsize,
    output logic [1:0]   arburst,
    output logic         arvalid,
    input  logic         arready,
    input  logic [31:0]  rdata,
    input  logic [1:0]   rresp,
    input  logic         rlast,
    input  logic         rvalid,
    output logic         rready
);
    localparam int NUM_WORDS = 4;

    typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_RESP} state_t;

    state_t                        state, state_nxt;
    logic                          accept, beat, last_beat;
    logic [1:0]                    cnt;
    logic                          err;
    logic [31:0]                   addr_q;
    logic [NUM_WORDS-1:0][31:0]    words;

    assign accept    = inst_req && (state == S_IDLE);
    assign beat      = (state == S_R) && rvalid;
    assign last_beat = beat && (rlast || cnt == 2'd3);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept)    state_nxt = S_AR;
            S_AR:   if (arready)   state_nxt = S_R;
            S_R:    if (last_beat) state_nxt = S_RESP;
            S_RESP:                state_nxt = S_IDLE;
            default:               state_nxt = S_IDLE;
        endcase
    end

    // A short burst (rlast before the 4th beat) is reported as a bus error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q <= 32'd0;
            cnt    <= 2'd0;
            err    <= 1'b0;
        end else if (accept) begin
            addr_q <= {inst_addr[31:4], 4'b0000};
            cnt    <= 2'd0;
            err    <= 1'b0;
        end else if (beat) begin
            cnt <= cnt + 2'd1;
            if (rresp != 2'b00 || (rlast && cnt != 2'd3))
                err <= 1'b1;
        end
    end

    // Words are only overwritten by beats, so the group holds after RESP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      words      <= '0;
        else if (beat) words[cnt] <= rdata;
    end

    assign inst_addr_ok = (state == S_IDLE);
    assign inst_data_ok = (state == S_RESP);
    assign inst_rdata   = words;
    assign inst_bus_err = err;

    assign arid    = AXI_ID;
    assign araddr  = addr_q;
    assign arlen   = 8'd3;
    assign arsize  = 3'd2;
    assign arburst = 2'b01;
    assign arvalid = (state == S_AR);
    assign rready  = (state == S_R);
endmodule

// File: tb/tb_inst_axi_bridge.sv
// Directed bench for inst_axi_bridge: table of fetch bursts plus hand-written
// sequences for AR stall, reset mid-burst and back-to-back requests.
module tb_inst_axi_bridge;
    logic         clk = 1'b0;
    logic         rst;
    logic         inst_req;
    logic [31:0]  inst_addr;
    logic         inst_addr_ok, inst_data_ok, inst_bus_err;
    logic [127:0] inst_rdata;
    logic [3:0]   arid;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         arvalid, arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rlast, rvalid, rready;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    inst_axi_bridge #(.AXI_ID(4'd0)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .inst_rdata(inst_rdata), .inst_bus_err(inst_bus_err),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready)
    );

    typedef struct {
        logic [31:0]       addr;
        int                ar_dly;
        int                nbeats;
        logic [3:0][31:0]  data;
        logic [3:0][1:0]   resp;
        logic [3:0][2:0]   gap;
        logic [31:0]       exp_araddr;
        logic [127:0]      exp_rdata;
        logic              exp_err;
    } vec_t;

    vec_t vecs [9];

    function automatic vec_t mk(logic [31:0] addr, int dly, int nb,
                                logic [127:0] data, logic [7:0] resp,
                                logic [11:0] gap, logic [31:0] ea,
                                logic [127:0] ed, logic ee);
        vec_t v;
        v.addr = addr; v.ar_dly = dly; v.nbeats = nb; v.data = data;
        v.resp = resp; v.gap = gap; v.exp_araddr = ea; v.exp_rdata = ed;
        v.exp_err = ee;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered with the bridge in AR; leaves it in R.
    task automatic ar_phase(input int dly, input logic [31:0] exp_addr);
        chk("arid", arid, 4'd0);
        chk("arlen", arlen, 8'd3);
        chk("arsize", arsize, 3'd2);
        chk("arburst", arburst, 2'b01);
        arready = 1'b0;
        for (int d = 0; d < dly; d++) begin
            chk("ar_stall_arvalid", arvalid, 1'b1);
            chk("ar_stall_araddr", araddr, exp_addr);
            chk("ar_stall_addr_ok", inst_addr_ok, 1'b0);
            chk("ar_stall_rready", rready, 1'b0);
            step();
        end
        chk("arvalid", arvalid, 1'b1);
        chk("araddr", araddr, exp_addr);
        arready = 1'b1;
        step();
        arready = 1'b0;
        chk("r_rready", rready, 1'b1);
        chk("r_arvalid", arvalid, 1'b0);
    endtask

    // Entered with the bridge in R; returns one cycle after inst_data_ok.
    task automatic r_phase(input vec_t v);
        for (int i = 0; i < v.nbeats; i++) begin
            rvalid = 1'b0;
            for (int g = 0; g < int'(v.gap[i]); g++) begin
                step();
                chk("gap_data_ok", inst_data_ok, 1'b0);
                chk("gap_rready", rready, 1'b1);
            end
            rvalid = 1'b1;
            rdata  = v.data[i];
            rresp  = v.resp[i];
            rlast  = (i == v.nbeats - 1);
            step();
            if (i != v.nbeats - 1) chk("beat_data_ok", inst_data_ok, 1'b0);
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = 2'b00;
        chk("data_ok", inst_data_ok, 1'b1);
        chk("inst_rdata", inst_rdata, v.exp_rdata);
        chk("inst_bus_err", inst_bus_err, v.exp_err);
        chk("resp_rready", rready, 1'b0);
        step();
        chk("data_ok_pulse", inst_data_ok, 1'b0);
        chk("idle_addr_ok", inst_addr_ok, 1'b1);
        chk("rdata_hold", inst_rdata, v.exp_rdata);
    endtask

    task automatic run_burst(input vec_t v);
        chk("pre_addr_ok", inst_addr_ok, 1'b1);
        inst_req  = 1'b1;
        inst_addr = v.addr;
        step();
        inst_req  = 1'b0;
        ar_phase(v.ar_dly, v.exp_araddr);
        r_phase(v);
    endtask

    initial begin
        vecs[0] = mk(32'hBFC0_0004, 0, 4, {32'h44, 32'h33, 32'h22, 32'h11}, 8'h00, 12'h000,
                     32'hBFC0_0000, 128'h00000044_00000033_00000022_00000011, 1'b0);
        vecs[1] = mk(32'h1000_001C, 5, 4, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 8'h00,
                     {3'd2, 3'd0, 3'd2, 3'd0},
                     32'h1000_0010, 128'h000000A3_000000A2_000000A1_000000A0, 1'b0);
        vecs[2] = mk(32'h2000_0028, 1, 4, {32'hC3, 32'hC2, 32'hC1, 32'hC0},
                     {2'b00, 2'b00, 2'b10, 2'b00}, 12'h000,
                     32'h2000_0020, 128'h000000C3_000000C2_000000C1_000000C0, 1'b1);
        vecs[3] = mk(32'h3000_0030, 0, 4, {32'hD3, 32'hD2, 32'hD1, 32'hD0}, 8'h00, 12'h000,
                     32'h3000_0030, 128'h000000D3_000000D2_000000D1_000000D0, 1'b0);
        vecs[4] = mk(32'h4000_000F, 0, 2, {32'h0, 32'h0, 32'hE1, 32'hE0}, 8'h00, 12'h000,
                     32'h4000_0000, 128'h000000D3_000000D2_000000E1_000000E0, 1'b1);
        vecs[5] = mk(32'hFFFF_FFFF, 2, 4, {32'hF3, 32'hF2, 32'hF1, 32'hF0},
                     {2'b11, 2'b00, 2'b00, 2'b00}, {3'd0, 3'd1, 3'd0, 3'd0},
                     32'hFFFF_FFF0, 128'h000000F3_000000F2_000000F1_000000F0, 1'b1);
        vecs[6] = mk(32'h6000_0044, 0, 4, {32'h64, 32'h63, 32'h62, 32'h61}, 8'h00, 12'h000,
                     32'h6000_0040, 128'h00000064_00000063_00000062_00000061, 1'b0);
        vecs[7] = mk(32'h7000_0000, 0, 4, {32'h74, 32'h73, 32'h72, 32'h71}, 8'h00, 12'h000,
                     32'h7000_0000, 128'h00000074_00000073_00000072_00000071, 1'b0);
        vecs[8] = mk(32'h7100_0010, 0, 4, {32'h84, 32'h83, 32'h82, 32'h81}, 8'h00, 12'h000,
                     32'h7100_0010, 128'h00000084_00000083_00000082_00000081, 1'b0);

        rst = 1'b0; inst_req = 1'b0; inst_addr = '0; arready = 1'b0;
        rdata = '0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
        #2;
        chk("rst_araddr", araddr, 32'd0);
        chk("rst_rdata", inst_rdata, 128'd0);
        chk("rst_data_ok", inst_data_ok, 1'b0);
        chk("rst_arvalid", arvalid, 1'b0);
        chk("rst_rready", rready, 1'b0);
        chk("rst_bus_err", inst_bus_err, 1'b0);
        step();
        step();
        rst = 1'b1;
        chk("rst_addr_ok", inst_addr_ok, 1'b1);

        for (int k = 0; k < 6; k++) run_burst(vecs[k]);

        // Reset asserted between clock edges after the 2nd beat.
        inst_req = 1'b1; inst_addr = 32'h5000_0008;
        step();
        inst_req = 1'b0; arready = 1'b1;
        step();
        arready = 1'b0; rvalid = 1'b1; rdata = 32'h55;
        step();
        rdata = 32'h56;
        step();
        rvalid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_rdata", inst_rdata, 128'd0);
        chk("mid_rst_araddr", araddr, 32'd0);
        chk("mid_rst_rready", rready, 1'b0);
        chk("mid_rst_arvalid", arvalid, 1'b0);
        chk("mid_rst_data_ok", inst_data_ok, 1'b0);
        chk("mid_rst_bus_err", inst_bus_err, 1'b0);
        step();
        rst = 1'b1;
        rvalid = 1'b1; rdata = 32'h99; rlast = 1'b1;
        chk("stray_rready", rready, 1'b0);
        step();
        chk("stray_rready2", rready, 1'b0);
        step();
        rvalid = 1'b0; rlast = 1'b0;
        chk("stray_rdata", inst_rdata, 128'd0);
        chk("stray_data_ok", inst_data_ok, 1'b0);
        run_burst(vecs[6]);

        // inst_req held high across two fetches.
        inst_req = 1'b1; inst_addr = vecs[7].addr;
        step();
        inst_addr = vecs[8].addr;
        ar_phase(0, vecs[7].exp_araddr);
        r_phase(vecs[7]);
        step();
        inst_req = 1'b0;
        chk("b2b_addr_ok", inst_addr_ok, 1'b0);
        ar_phase(0, vecs[8].exp_araddr);
        r_phase(vecs[8]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
